// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, instruction memory address, IF/ID output register
module instruction_fetch_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter int unsigned     ILEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     PC_STEP      = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [XLEN-1:0] mem_address_o,
  input  logic [ILEN-1:0] mem_instruction_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            halt_i,
  input  logic            out_ready_i,
  output logic            out_valid_o,
  output logic [ILEN-1:0] out_instruction_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_pc_next_o,
  output logic            fault_o,
  output logic [XLEN-1:0] fault_pc_o,
  output logic [31:0]     fetch_count_o
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(PC_STEP);

  // BOOT is a single bubble cycle after reset; FAULT is terminal until reset
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [ILEN-1:0] out_instruction_q, out_instruction_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_pc_next_q, out_pc_next_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic [XLEN-1:0] pc_plus_step;
  logic            handshake;
  logic            redirect_misaligned;
  logic            can_advance;

  // Shared decode of the current-cycle conditions; PC increment wraps modulo 2^XLEN
  always_comb begin
    pc_plus_step        = pc_q + PcStep;
    handshake           = out_valid_q & out_ready_i;
    redirect_misaligned = redirect_i & (redirect_target_i[1:0] != 2'b00);
    can_advance         = ~out_valid_q | out_ready_i;
  end

  // Next-state logic, priority: misaligned redirect, redirect, halt, advance, stall
  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    out_valid_d       = out_valid_q;
    out_instruction_d = out_instruction_q;
    out_pc_d          = out_pc_q;
    out_pc_next_d     = out_pc_next_q;
    fault_d           = fault_q;
    fault_pc_d        = fault_pc_q;
    fetch_count_d     = fetch_count_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A handshake is consumed by decode regardless of what else happens this edge
        if (handshake) begin
          fetch_count_d = fetch_count_q + 32'd1;
        end

        if (redirect_misaligned) begin
          fault_d     = 1'b1;
          fault_pc_d  = redirect_target_i;
          out_valid_d = 1'b0;
          state_d     = ST_FAULT;
        end else if (redirect_i) begin
          pc_d        = redirect_target_i;
          out_valid_d = 1'b0;
        end else if (halt_i) begin
          if (handshake) begin
            out_valid_d = 1'b0;
          end
        end else if (can_advance) begin
          out_instruction_d = mem_instruction_i;
          out_pc_d          = pc_q;
          out_pc_next_d     = pc_plus_step;
          out_valid_d       = 1'b1;
          pc_d              = pc_plus_step;
        end
      end

      ST_FAULT: begin
        out_valid_d = 1'b0;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Single state register for the FSM and all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= ST_BOOT;
      pc_q              <= RESET_VECTOR;
      out_valid_q       <= 1'b0;
      out_instruction_q <= '0;
      out_pc_q          <= '0;
      out_pc_next_q     <= '0;
      fault_q           <= 1'b0;
      fault_pc_q        <= '0;
      fetch_count_q     <= '0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      out_valid_q       <= out_valid_d;
      out_instruction_q <= out_instruction_d;
      out_pc_q          <= out_pc_d;
      out_pc_next_q     <= out_pc_next_d;
      fault_q           <= fault_d;
      fault_pc_q        <= fault_pc_d;
      fetch_count_q     <= fetch_count_d;
    end
  end

  // Memory address is the live PC, with no extra register stage
  always_comb begin
    mem_address_o     = pc_q;
    out_valid_o       = out_valid_q;
    out_instruction_o = out_instruction_q;
    out_pc_o          = out_pc_q;
    out_pc_next_o     = out_pc_next_q;
    fault_o           = fault_q;
    fault_pc_o        = fault_pc_q;
    fetch_count_o     = fetch_count_q;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk_i;
  logic        rst_ni;
  logic [63:0] mem_address_o;
  logic [31:0] mem_instruction_i;
  logic        redirect_i;
  logic [63:0] redirect_target_i;
  logic        halt_i;
  logic        out_ready_i;
  logic        out_valid_o;
  logic [31:0] out_instruction_o;
  logic [63:0] out_pc_o;
  logic [63:0] out_pc_next_o;
  logic        fault_o;
  logic [63:0] fault_pc_o;
  logic [31:0] fetch_count_o;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .mem_address_o     (mem_address_o),
    .mem_instruction_i (mem_instruction_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .halt_i            (halt_i),
    .out_ready_i       (out_ready_i),
    .out_valid_o       (out_valid_o),
    .out_instruction_o (out_instruction_o),
    .out_pc_o          (out_pc_o),
    .out_pc_next_o     (out_pc_next_o),
    .fault_o           (fault_o),
    .fault_pc_o        (fault_pc_o),
    .fetch_count_o     (fetch_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction memory: word n holds 0x13 + n
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h0000_0013 + a[33:2];
  endfunction

  assign mem_instruction_i = mem_word(mem_address_o);

  // Reference model: architectural view of the fetch stage
  logic [63:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_out_pc;
  logic        m_fault;
  logic [63:0] m_fault_pc;
  logic [31:0] m_count;
  bit          m_boot;

  task automatic model_reset();
    m_pc = 64'h0; m_valid = 1'b0; m_instr = '0; m_out_pc = '0;
    m_fault = 1'b0; m_fault_pc = '0; m_count = '0; m_boot = 1'b1;
  endtask

  task automatic model_edge();
    bit accepted;
    if (!rst_ni) return;
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    if (m_fault) return;
    accepted = m_valid && out_ready_i;
    if (accepted) m_count = m_count + 1;
    if (redirect_i && redirect_target_i[1:0] != 2'b00) begin
      m_fault = 1'b1; m_fault_pc = redirect_target_i; m_valid = 1'b0;
    end else if (redirect_i) begin
      m_pc = redirect_target_i; m_valid = 1'b0;
    end else if (halt_i) begin
      if (accepted) m_valid = 1'b0;
    end else if (!m_valid || out_ready_i) begin
      m_instr = mem_word(m_pc); m_out_pc = m_pc; m_valid = 1'b1;
      m_pc = m_pc + 64'd4;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  mem_address_o, m_pc);
    check({tag, ".valid"}, 64'(out_valid_o), 64'(m_valid));
    check({tag, ".instr"}, 64'(out_instruction_o), 64'(m_instr));
    check({tag, ".pc"},    out_pc_o, m_out_pc);
    check({tag, ".pcnx"},  out_pc_next_o, (m_out_pc == 64'h0 && m_instr == 32'h0) ? 64'h0 : m_out_pc + 64'd4);
    check({tag, ".fault"}, 64'(fault_o), 64'(m_fault));
    check({tag, ".fpc"},   fault_pc_o, m_fault_pc);
    check({tag, ".cnt"},   64'(fetch_count_o), 64'(m_count));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_i);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit rd, input logic [63:0] tgt, input bit hl, input bit rdy);
    redirect_i = rd; redirect_target_i = tgt; halt_i = hl; out_ready_i = rdy;
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk_i);
    model_edge();
    #3;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_valid"}, 64'(out_valid_o), 64'h0);
    check({tag, ".rst_pc"},    out_pc_o, 64'h0);
    check({tag, ".rst_addr"},  mem_address_o, 64'h0);
    check({tag, ".rst_fault"}, 64'(fault_o), 64'h0);
    check({tag, ".rst_cnt"},   64'(fetch_count_o), 64'h0);
    check_all({tag, ".rst"});
    tick({tag, ".held"});
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Boot bubble, then sequential fetch
    tick("boot");
    check("boot.valid", 64'(out_valid_o), 64'h0);
    tick("f0");
    check("f0.pc", out_pc_o, 64'h0);
    check("f0.instr", 64'(out_instruction_o), 64'h13);
    tick("f1");
    check("f1.pc", out_pc_o, 64'h4);
    tick("f2");
    check("f2.pc", out_pc_o, 64'h8);
    check("f2.instr", 64'(out_instruction_o), 64'h15);

    // Stall with OutPc=8
    set_in(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall.pc", out_pc_o, 64'h8);
    check("stall.addr", mem_address_o, 64'hC);
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    tick("unstall");
    check("unstall.pc", out_pc_o, 64'hC);

    // Redirect with a handshake on the same edge
    set_in(1'b1, 64'h100, 1'b0, 1'b1);
    tick("redir");
    check("redir.valid", 64'(out_valid_o), 64'h0);
    check("redir.addr", mem_address_o, 64'h100);
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    tick("redir.f");
    check("redir.f.pc", out_pc_o, 64'h100);
    check("redir.f.pcnx", out_pc_next_o, 64'h104);

    // Halt: hold while stalled, drain on ready, resume at held PC
    set_in(1'b0, 64'h0, 1'b1, 1'b0);
    tick("halt0");
    tick("halt1");
    check("halt.valid", 64'(out_valid_o), 64'h1);
    set_in(1'b0, 64'h0, 1'b1, 1'b1);
    tick("halt.drain");
    check("halt.drain.valid", 64'(out_valid_o), 64'h0);
    tick("halt.idle");
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    tick("halt.resume");
    check("halt.resume.pc", out_pc_o, 64'h104);

    // PC wrap-around
    set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
    tick("wrap.redir");
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    tick("wrap.top");
    check("wrap.top.pc", out_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.top.pcnx", out_pc_next_o, 64'h0);
    tick("wrap.zero");
    check("wrap.zero.pc", out_pc_o, 64'h0);

    // Randomized traffic with aligned redirects
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) == 0),
             {$urandom, $urandom} & ~64'h3,
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) != 0));
      tick("rand");
    end

    // Asynchronous reset mid-stall
    set_in(1'b0, 64'h0, 1'b0, 1'b0);
    tick("pre.stall");
    async_reset("stallrst");
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick("post.rst");

    // Misaligned redirect faults and freezes the unit
    set_in(1'b1, 64'h102, 1'b0, 1'b1);
    tick("fault");
    check("fault.flag", 64'(fault_o), 64'h1);
    check("fault.fpc", fault_pc_o, 64'h102);
    check("fault.valid", 64'(out_valid_o), 64'h0);
    set_in(1'b1, 64'h200, 1'b0, 1'b1);
    tick("fault.ign");
    check("fault.ign.addr", mem_address_o, m_pc);
    for (int i = 0; i < 20; i++) begin
      set_in($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1);
      tick("fault.frozen");
    end
    check("fault.still.valid", 64'(out_valid_o), 64'h0);
    async_reset("faultrst");
    set_in(1'b0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick("after.fault");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
